instr_store_mc: RTL

//  Multi-channel, host-loadable instruction store for the TSP front end. Holds DEPTH

---
 rtl/tsp_instr_pkg.sv | 18 +
 rtl/instr_load_ctrl.sv | 112 +++++++++++
 rtl/instr_store_mc.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tsp_instr_pkg.sv
// Shared types for the TSP instruction store.
// Contents:
//   instr_t       - one instruction word at the default 32-bit width
//   INSTR_NOP     - the all-zero word that marks the end of a program
//   load_state_e  - states of the host load FSM (IDLE, LOAD, DONE)
package tsp_instr_pkg;

  typedef logic [31:0] instr_t;

  localparam instr_t INSTR_NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/instr_load_ctrl.sv
// Host load controller for the instruction store. Accepts a (base, len) program
// window and then streams beats into consecutive addresses.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   load_start_i      begin a load; samples load_base_i / load_len_i (IDLE only)
//   load_base_i       first word address
//   load_len_i        word count, 0..DEPTH
//   load_valid_i      beat valid from the bridge
//   load_ready_o      beat accepted this cycle (LOAD state)
//   load_busy_o       LOAD or DONE state; fetches are held off
//   load_done_o       one-cycle pulse in DONE after the last beat
//   load_err_o        one-cycle pulse after an out-of-range start
//   wr_en_o/wr_addr_o memory write strobe and address for the current beat
module instr_load_ctrl
  import tsp_instr_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start_i,
  input  logic [ADDR_WIDTH-1:0] load_base_i,
  input  logic [ADDR_WIDTH:0]   load_len_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  output logic                  load_busy_o,
  output logic                  load_done_o,
  output logic                  load_err_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o
);

  localparam logic [ADDR_WIDTH+1:0] DEPTH = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

  load_state_e           state_q;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  ready_q, busy_q, done_q, err_q;

  // End of window computed two bits wider so base+len can never wrap.
  logic [ADDR_WIDTH+1:0] end_addr;
  logic                  range_ok;
  assign end_addr = {2'b00, load_base_i} + {1'b0, load_len_i};
  assign range_ok = (end_addr <= DEPTH);

  // ready_q is only ever set in LOAD, so it doubles as the state qualifier.
  logic beat;
  assign beat = load_valid_i & ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start_i) begin
            if (!range_ok) begin
              err_q <= 1'b1;
            end else begin
              ptr_q  <= load_base_i;
              cnt_q  <= load_len_i;
              busy_q <= 1'b1;
              if (load_len_i == '0) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= LOAD;
                ready_q <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          if (beat) begin
            ptr_q <= ptr_q + 1'b1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == (ADDR_WIDTH+1)'(1)) begin
              state_q <= DONE;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready_o = ready_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;
  assign load_err_o   = err_q;
  assign wr_en_o      = beat;
  assign wr_addr_o    = ptr_q;

endmodule

// File: rtl/instr_store_mc.sv
// Multi-channel host-loadable instruction store. DEPTH = 2**ADDR_WIDTH words,
// NUM_CH independent one-cycle fetch ports, one valid/ready load port.
// An all-zero word (NOP) marks end-of-program.
// Build option: define TSP_INSTR_PARITY_EN to store an even-parity bit per word
// and flag mismatches on fetch_perr; otherwise fetch_perr is held at 0.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   fetch_req     per-channel request; fetch_addr per-channel word address
//   fetch_data    fetched word (holds when no request or while loading)
//   fetch_valid   fetched word is a good non-NOP instruction
//   fetch_end     fetched word is NOP
//   fetch_perr    parity error on the fetched word
//   load_*        host load port, see instr_load_ctrl
module instr_store_mc
  import tsp_instr_pkg::*;
#(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int NUM_CH      = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_CH-1:0]                   fetch_req,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]   fetch_addr,
  output logic [NUM_CH-1:0][INSTR_WIDTH-1:0]  fetch_data,
  output logic [NUM_CH-1:0]                   fetch_valid,
  output logic [NUM_CH-1:0]                   fetch_end,
  output logic [NUM_CH-1:0]                   fetch_perr,
  input  logic                                load_start,
  input  logic [ADDR_WIDTH-1:0]               load_base,
  input  logic [ADDR_WIDTH:0]                 load_len,
  input  logic [INSTR_WIDTH-1:0]              load_data,
  input  logic                                load_valid,
  output logic                                load_ready,
  output logic                                load_busy,
  output logic                                load_done,
  output logic                                load_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(INSTR_NOP);
`ifdef TSP_INSTR_PARITY_EN
  localparam int MW = INSTR_WIDTH + 1;
`else
  localparam int MW = INSTR_WIDTH;
`endif

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [MW-1:0]         wr_word;

  instr_load_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .load_base_i  (load_base),
    .load_len_i   (load_len),
    .load_valid_i (load_valid),
    .load_ready_o (load_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done),
    .load_err_o   (load_err),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr)
  );

`ifdef TSP_INSTR_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  // Storage is deliberately not reset: a reset mid-load must leave earlier
  // words intact.
  logic [MW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_word;
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [MW-1:0]          rd_word;
    logic [INSTR_WIDTH-1:0] word;
    logic                   perr_d;
    logic [INSTR_WIDTH-1:0] data_q;
    logic                   valid_q, end_q, perr_q;

    assign rd_word = mem_q[fetch_addr[c]];
    assign word    = rd_word[INSTR_WIDTH-1:0];
`ifdef TSP_INSTR_PARITY_EN
    assign perr_d  = rd_word[MW-1] ^ (^word);
`else
    assign perr_d  = 1'b0;
`endif

    // A blocked or absent request clears the flags but keeps the last word,
    // so the sequencer simply retries.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q  <= '1;
        valid_q <= 1'b0;
        end_q   <= 1'b0;
        perr_q  <= 1'b0;
      end else if (fetch_req[c] && !load_busy) begin
        data_q  <= word;
        valid_q <= !perr_d && (word != NOP);
        end_q   <= !perr_d && (word == NOP);
        perr_q  <= perr_d;
      end else begin
        valid_q <= 1'b0;
        end_q   <= 1'b0;
        perr_q  <= 1'b0;
      end
    end

    assign fetch_data[c]  = data_q;
    assign fetch_valid[c] = valid_q;
    assign fetch_end[c]   = end_q;
    assign fetch_perr[c]  = perr_q;
  end

endmodule
